// File: rtl/fmul_arb.sv
// Round-robin arbiter sharing one fp32 multiplier among NUM_REQ requesters.
// Define FMUL_ARB_OUT_REG_EN to add an output register stage (latency 2 instead of 1).
module fmul_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_vld,
    output logic [NUM_REQ-1:0]     req_rdy,
    input  logic [NUM_REQ*32-1:0]  req_a,
    input  logic [NUM_REQ*32-1:0]  req_b,
    output logic                   rsp_vld,
    input  logic                   rsp_rdy,
    output logic [31:0]            rsp_data,
    output logic [ID_W-1:0]        rsp_id
);
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic            s1_vld_q, s1_vld_d;
    logic [31:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic [31:0]     fmul_res;

    logic            stall, grant_vld, accept;
    logic [ID_W-1:0] grant_id, idx;
    logic [31:0]     sel_a, sel_b;

    assign stall  = rsp_vld & ~rsp_rdy;
    assign accept = rst_n & ~stall & grant_vld;

    // Search starts one past the last winner and wraps.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(last_grant_q) + i) % NUM_REQ);
            if (!grant_vld && req_vld[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
        req_rdy = '0;
        if (accept) req_rdy[grant_id] = 1'b1;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                sel_a = req_a[32*k +: 32];
                sel_b = req_b[32*k +: 32];
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        s1_vld_d     = s1_vld_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_id_d      = s1_id_q;
        if (!stall) begin
            s1_vld_d = accept;
            if (accept) begin
                last_grant_d = grant_id;
                s1_a_d       = sel_a;
                s1_b_d       = sel_b;
                s1_id_d      = grant_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            s1_vld_q     <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_id_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            s1_vld_q     <= s1_vld_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_id_q      <= s1_id_d;
        end
    end

    fmul u_fmul (
        .a_in   (s1_a_q),
        .b_in   (s1_b_q),
        .result (fmul_res)
    );

`ifdef FMUL_ARB_OUT_REG_EN
    logic            s2_vld_q, s2_vld_d;
    logic [31:0]     s2_data_q, s2_data_d;
    logic [ID_W-1:0] s2_id_q, s2_id_d;

    always_comb begin
        s2_vld_d  = s2_vld_q;
        s2_data_d = s2_data_q;
        s2_id_d   = s2_id_q;
        if (!stall) begin
            s2_vld_d  = s1_vld_q;
            s2_data_d = fmul_res;
            s2_id_d   = s1_id_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
            s2_id_q   <= '0;
        end else begin
            s2_vld_q  <= s2_vld_d;
            s2_data_q <= s2_data_d;
            s2_id_q   <= s2_id_d;
        end
    end

    assign rsp_vld  = s2_vld_q;
    assign rsp_data = s2_data_q;
    assign rsp_id   = s2_id_q;
`else
    // S1 operands reset to zero, so the product (and rsp_data) is zero after reset.
    assign rsp_vld  = s1_vld_q;
    assign rsp_data = fmul_res;
    assign rsp_id   = s1_id_q;
`endif
endmodule

// Combinational fp32 multiply: round-to-nearest-even, subnormals flushed to zero,
// any NaN or inf*0 gives canonical quiet NaN 0x7FC00000.
module fmul (
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] result
);
    logic        sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0] prod;
    logic [22:0] frac;
    logic        guard, sticky;
    logic [23:0] rnd;
    logic [9:0]  esum;

    always_comb begin
        sgn    = a_in[31] ^ b_in[31];
        a_zero = (a_in[30:23] == 8'd0);
        b_zero = (b_in[30:23] == 8'd0);
        a_inf  = (a_in[30:23] == 8'hFF) && (a_in[22:0] == 23'd0);
        b_inf  = (b_in[30:23] == 8'hFF) && (b_in[22:0] == 23'd0);
        a_nan  = (a_in[30:23] == 8'hFF) && (a_in[22:0] != 23'd0);
        b_nan  = (b_in[30:23] == 8'hFF) && (b_in[22:0] != 23'd0);
        prod   = {24'd0, 1'b1, a_in[22:0]} * {24'd0, 1'b1, b_in[22:0]};
        if (prod[47]) begin
            frac   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
        end else begin
            frac   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        rnd  = {1'b0, frac} + {23'd0, guard & (sticky | frac[0])};
        // Biased exponent sum plus normalisation and rounding carries; bias removed below.
        esum = {2'b0, a_in[30:23]} + {2'b0, b_in[30:23]} + {9'd0, prod[47]} + {9'd0, rnd[23]};

        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            result = 32'h7FC0_0000;
        else if (a_inf || b_inf)
            result = {sgn, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
            result = {sgn, 31'd0};
        else if (esum >= 10'd382)
            result = {sgn, 8'hFF, 23'd0};
        else if (esum <= 10'd127)
            result = {sgn, 31'd0};
        else
            result = {sgn, 8'(esum - 10'd127), rnd[22:0]};
    end
endmodule

// File: doc/fmul_arb.md
FMUL_ARB -- requirements
Module: fmul_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one fmul instance (2..8).
REQ-002 Parameter ID_W, default 2, width of requester index (ceil(log2(NUM_REQ))).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 req_vld  input  NUM_REQ  per-requester operand-valid.
REQ-006 req_rdy  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-007 req_a  input  NUM_REQ*32  fp32 operand A per requester; requester k at bits [32k+31:32k].
REQ-008 req_b  input  NUM_REQ*32  fp32 operand B per requester, same packing.
REQ-009 rsp_vld  output  1  result valid.
REQ-010 rsp_rdy  input  1  downstream accepts result.
REQ-011 rsp_data  output  32  fp32 product from the shared fmul.
REQ-012 rsp_id  output  ID_W  index of the requester that owns rsp_data.

Function
REQ-013 Block SHALL instantiate exactly one fmul (a_in, b_in, result); all requesters time-share it.
REQ-014 Accept: requester k is accepted on an edge where req_vld[k] and req_rdy[k] are both 1.
REQ-015 req_rdy SHALL be combinational from req_vld, rr pointer and stall; at most one bit high; never high for a requester with req_vld low.
REQ-016 Arbitration: round-robin; search starts at (last_grant+1) mod NUM_REQ, wraps past NUM_REQ-1 to 0.
REQ-017 last_grant SHALL update only on an accept; idle cycles leave it unchanged.
REQ-018 Stage S1: on accept, operands and id captured into s1 registers, s1_vld set; fmul driven only from s1 registers.
REQ-019 Output is held (stall) while rsp_vld=1 and rsp_rdy=0; during stall req_rdy=0 and every pipeline register holds its value.
REQ-020 Throughput: one accept per cycle when rsp_rdy=1 continuously.
REQ-021 rsp_data/rsp_id SHALL stay stable while rsp_vld=1 and rsp_rdy=0.
REQ-022 Pipeline stage empties when its result is consumed and no new accept occurs; same-edge consume plus accept SHALL both take effect.
REQ-023 Products SHALL be bit-identical to a standalone fmul on the same operands; no rounding or special-case handling is added.
REQ-024 Results SHALL leave in accept order; no reordering, drop or duplication.

Reset
REQ-025 With rst_n=0 at an edge: s1_vld=0, s2_vld=0, last_grant=NUM_REQ-1 (so requester 0 wins first), rsp_vld=0.
REQ-026 rsp_data and rsp_id SHALL reset to 0.
REQ-027 req_rdy SHALL be 0 during any cycle in which rst_n=0.
REQ-028 Reset mid-operation SHALL discard all in-flight products; no rsp_vld after reset release until a new accept.

Configuration
REQ-029 Macro FMUL_ARB_OUT_REG_EN: when defined, a second register S2 captures fmul result and id from S1; rsp_* come from S2; latency is 2 edges from accept to rsp_vld.
REQ-030 When FMUL_ARB_OUT_REG_EN is undefined, rsp_data is driven combinationally from fmul on S1 registers; rsp_vld=s1_vld; latency is 1 edge.
REQ-031 Both builds SHALL obey REQ-014..REQ-028 identically apart from latency and pipeline depth.

Verification
REQ-032 Single op: req 0 A=0x3FC00000 (1.5), B=0x40000000 (2.0), rsp_rdy=1 -> rsp_data=0x40400000, rsp_id=0, latency 1 (2 with macro).
REQ-033 All four req_vld held high from reset, rsp_rdy=1 -> grant order 0,1,2,3,0; rsp_id sequence identical; one result per cycle.
REQ-034 Backpressure: rsp_rdy=0 for 3 cycles with rsp_vld=1 -> rsp_data/rsp_id unchanged, req_rdy=0 all 3 cycles, no lost or duplicated result after release.
REQ-035 Fairness: req 1 and req 3 held high, last_grant=1 -> next grant 3, then 1; req 0 and 2 never granted.
REQ-036 Reset mid-flight: accept on req 2, assert rst_n=0 next cycle -> rsp_vld=0, rsp_data=0, first post-reset grant goes to requester 0.
REQ-037 Random sweep: 2000 random operand pairs over all requesters with random rsp_rdy -> every product matches a standalone fmul reference, in accept order.
